xnor_based_carry_lookahead_adder32: RTL and testbench
=====================================================

Name: xnor_based_carry_lookahead_adder32

Overview:
- Exact 32-bit unsigned adder with a 33-bit registered result, intended for the arithmetic-block library.
- Uses a carry-lookahead carry network with XNOR-based sum generation.
- The combinational core is followed by one output register stage, so the block drops into clocked datapaths with a fixed 1-cycle latency.
- There is no carry-in and no handshake.

Parameters:
- DATA_W, 32, operand width. Only 32 is required to be supported; the result width is DATA_W+1.
- CLA_GRP, 4, bits per lookahead group. DATA_W must be divisible by CLA_GRP, giving 8 groups of 4 at the defaults.

Ports:
- clk_i  input  1  clock; rising-edge active.
- rst_ni  input  1  asynchronous active-low reset.
- add1_i  input  32  operand A, unsigned.
- add2_i  input  32  operand B, unsigned.
- result_o  output  33  registered sum. Bit 32 is the carry-out; bits 31:0 are the sum.

Behaviour:
- Reset:
  - While rst_ni=0, result_o=33'h0, forced asynchronously and independent of clk_i.
  - Release is synchronised by the clock edge: the first update happens on the first rising edge of clk_i after rst_ni=1.
- Function: on every rising edge of clk_i with rst_ni=1, result_o <= {1'b0,add1_i} + {1'b0,add2_i}.
  - The result is exact: no approximation and no truncation.
- Latency and throughput:
  - Latency is exactly 1 cycle from sampling edge to output.
  - A new operand pair is accepted every cycle.
  - result_o holds its value between edges.
- Internal structure (required):
  - Per bit: generate g=a&b and propagate p=a^b.
  - Sum bit s = XNOR(XNOR(a,b), c). This is functionally equal to a^b^c.
  - Per 4-bit group:
    - Lookahead carries c1..c4 computed from g/p/cin with no ripple inside the group.
    - Group generate G and group propagate P produced for the next level.
  - Second level: lookahead over the 8 groups, fed by G/P, produces the group carry-ins. Carry-in to bit 0 is 0.
  - Carry-out of bit 31 is result_o[32].
- Arithmetic rules:
  - Operands are unsigned.
  - No overflow condition exists because the output is 33 bits wide.
  - The maximum sum is FFFF_FFFF+FFFF_FFFF = 1_FFFF_FFFE.
- Boundaries:
  - All-ones propagate chain (e.g. FFFF_FFFF+0000_0001): the carry must reach bit 32 in the same cycle.
  - Zero operands give 0.
  - Operand changes between clock edges must not affect result_o.
- Reset mid-operation: asserting rst_ni clears result_o immediately. No pending result survives reset.

Test Plan:
- Reset:
  - Hold rst_ni=0 with add1_i=29AF_2430, add2_i=7A1B_9ABC and toggle clk_i → result_o=0_0000_0000.
  - Release reset, then one edge → result_o=0_A3CA_BEEC.
- Full propagate / carry-out:
  - 5555_5555+AAAA_AAAA → 0_FFFF_FFFF.
  - FFFF_FFFF+0000_0001 → 1_0000_0000.
  - FFFF_FFFF+FFFF_FFFF → 1_FFFF_FFFE.
- Mixed carries:
  - 8051_9860+8086_BA3E → 1_00D8_529E.
  - 8943_DEAF+DAAD_BAAD → 1_63F1_995C.
  - 0000_0001+DEAF_BEEF → 0_DEAF_BEF0.
- Identity and latency:
  - ABCD_1234+0 → 0_ABCD_1234, then 0+1234_5678 → 0_1234_5678 on the following edge.
  - Each result appears exactly one edge after its operands are applied.
- Back-to-back streaming:
  - Apply a new operand pair every cycle for at least 1000 cycles, using random values plus corner values (0, FFFF_FFFF, 8000_0000).
  - Compare each result against a reference sum delayed by 1 cycle → zero mismatches.
- Asynchronous reset mid-stream:
  - Drop rst_ni between clock edges → result_o=0 immediately, before the next edge.
  - After release, results resume with 1-cycle latency from the next sampled operands.

Source files
------------

// File: rtl/xnor_based_carry_lookahead_adder32.sv
// Purpose : exact unsigned DATA_W-bit adder, two-level carry-lookahead, XNOR sum, registered 33-bit result.
// Latency : 1 cycle (operands sampled on rising clk_i, result_o valid right after that edge).
// Backpres: none; a new operand pair is accepted on every edge, result_o holds between edges.
//
// Ports:
//   clk_i    - rising-edge clock
//   rst_ni   - asynchronous active-low reset, clears result_o
//   add1_i   - operand A (unsigned, DATA_W bits)
//   add2_i   - operand B (unsigned, DATA_W bits)
//   result_o - registered sum, bit DATA_W is the carry-out
module xnor_based_carry_lookahead_adder32 #(
  parameter int DATA_W  = 32,
  parameter int CLA_GRP = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] add1_i,
  input  logic [DATA_W-1:0] add2_i,
  output logic [DATA_W:0]   result_o
);

  localparam int NGRP = DATA_W / CLA_GRP;
  // Common vector width for both lookahead levels so one function serves both.
  localparam int LW   = (CLA_GRP > NGRP) ? CLA_GRP : NGRP;

  // Carry into position n of an n-bit span, written as a flat sum of products:
  //   c_n = g[n-1] | p[n-1]g[n-2] | ... | p[n-1..0]cin
  // Every product term depends only on g/p/cin, never on a lower carry, so
  // there is no ripple path through the span.
  function automatic logic lookahead(input logic [LW-1:0] g,
                                     input logic [LW-1:0] p,
                                     input logic          cin,
                                     input int            n);
    logic res;
    logic term;
    res = cin;
    for (int m = 0; m < LW; m++) begin
      if (m < n) res = res & p[m];
    end
    for (int k = 0; k < LW; k++) begin
      if (k < n) begin
        term = g[k];
        for (int m = 0; m < LW; m++) begin
          if (m > k && m < n) term = term & p[m];
        end
        res = res | term;
      end
    end
    return res;
  endfunction

  logic [DATA_W-1:0] gen;       // per-bit generate a&b
  logic [DATA_W-1:0] prop;      // per-bit propagate a^b
  logic [NGRP-1:0]   grp_g;     // group generate
  logic [NGRP-1:0]   grp_p;     // group propagate
  logic [NGRP:0]     grp_cin;   // carry into each group; top entry is the carry-out
  logic [DATA_W-1:0] carry;     // carry into each bit
  logic [DATA_W-1:0] sum;

  assign gen  = add1_i & add2_i;
  assign prop = add1_i ^ add2_i;

  // First level: group generate / propagate.
  always_comb begin : grp_level
    logic [LW-1:0] gx;
    logic [LW-1:0] px;
    gx    = '0;
    px    = '0;
    grp_g = '0;
    grp_p = '0;
    for (int j = 0; j < NGRP; j++) begin
      gx = '0;
      px = '0;
      gx[CLA_GRP-1:0] = gen[j*CLA_GRP +: CLA_GRP];
      px[CLA_GRP-1:0] = prop[j*CLA_GRP +: CLA_GRP];
      grp_g[j] = lookahead(gx, px, 1'b0, CLA_GRP);
      grp_p[j] = &prop[j*CLA_GRP +: CLA_GRP];
    end
  end

  // Second level: lookahead across groups. Carry-in to bit 0 is zero, so
  // grp_cin[0] is constant and grp_cin[NGRP] is the adder carry-out.
  always_comb begin : top_level
    logic [LW-1:0] gx;
    logic [LW-1:0] px;
    gx = '0;
    px = '0;
    gx[NGRP-1:0] = grp_g;
    px[NGRP-1:0] = grp_p;
    grp_cin = '0;
    for (int j = 0; j <= NGRP; j++) begin
      grp_cin[j] = lookahead(gx, px, 1'b0, j);
    end
  end

  // In-group carries c1..c(CLA_GRP-1), each looked ahead from the group carry-in.
  always_comb begin : bit_level
    logic [LW-1:0] gx;
    logic [LW-1:0] px;
    gx    = '0;
    px    = '0;
    carry = '0;
    for (int j = 0; j < NGRP; j++) begin
      gx = '0;
      px = '0;
      gx[CLA_GRP-1:0] = gen[j*CLA_GRP +: CLA_GRP];
      px[CLA_GRP-1:0] = prop[j*CLA_GRP +: CLA_GRP];
      for (int i = 0; i < CLA_GRP; i++) begin
        if (i == 0) carry[j*CLA_GRP] = grp_cin[j];
        else        carry[j*CLA_GRP + i] = lookahead(gx, px, grp_cin[j], i);
      end
    end
  end

  // s = XNOR(XNOR(a,b), c), equal to a^b^c.
  assign sum = (add1_i ~^ add2_i) ~^ carry;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) result_o <= '0;
    else         result_o <= {grp_cin[NGRP], sum};
  end

endmodule

// File: tb/tb_xnor_based_carry_lookahead_adder32.sv
module tb_xnor_based_carry_lookahead_adder32;

  logic        clk_i;
  logic        rst_ni;
  logic [31:0] add1_i;
  logic [31:0] add2_i;
  logic [32:0] result_o;

  int n_tests;
  int n_fail;

  xnor_based_carry_lookahead_adder32 #(.DATA_W(32), .CLA_GRP(4)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .add1_i   (add1_i),
    .add2_i   (add2_i),
    .result_o (result_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model: plain 33-bit arithmetic.
  function automatic logic [32:0] ref_sum(input logic [31:0] a, input logic [31:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic [31:0] pick_operand();
    int sel;
    sel = $urandom_range(0, 7);
    case (sel)
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    rst_ni = 1'b0;
    add1_i = 32'h29AF_2430;
    add2_i = 32'h7A1B_9ABC;
    #2;
    n_tests++;
    if (result_o !== 33'h0) begin
      n_fail++;
      $display("FAIL reset_initial: got %h expected %h", result_o, 33'h0);
    end
    repeat (3) @(posedge clk_i);
    #1;
    n_tests++;
    if (result_o !== 33'h0) begin
      n_fail++;
      $display("FAIL reset_held_clocks: got %h expected %h", result_o, 33'h0);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    n_tests++;
    if (result_o !== 33'h0_A3CA_BEEC) begin
      n_fail++;
      $display("FAIL reset_release_first: got %h expected %h", result_o, 33'h0_A3CA_BEEC);
    end
  endtask

  // Directed vectors with hand-derived expectations.
  task automatic test_directed();
    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic [32:0] ve [8];
    va[0] = 32'h5555_5555; vb[0] = 32'hAAAA_AAAA; ve[0] = 33'h0_FFFF_FFFF;
    va[1] = 32'hFFFF_FFFF; vb[1] = 32'h0000_0001; ve[1] = 33'h1_0000_0000;
    va[2] = 32'hFFFF_FFFF; vb[2] = 32'hFFFF_FFFF; ve[2] = 33'h1_FFFF_FFFE;
    va[3] = 32'h8051_9860; vb[3] = 32'h8086_BA3E; ve[3] = 33'h1_00D8_529E;
    va[4] = 32'h8943_DEAF; vb[4] = 32'hDAAD_BAAD; ve[4] = 33'h1_63F1_995C;
    va[5] = 32'h0000_0001; vb[5] = 32'hDEAF_BEEF; ve[5] = 33'h0_DEAF_BEF0;
    va[6] = 32'h0000_0000; vb[6] = 32'h0000_0000; ve[6] = 33'h0_0000_0000;
    va[7] = 32'h0000_000F; vb[7] = 32'h0000_0001; ve[7] = 33'h0_0000_0010;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      add1_i = va[i];
      add2_i = vb[i];
      @(posedge clk_i);
      #1;
      n_tests++;
      if (result_o !== ve[i]) begin
        n_fail++;
        $display("FAIL directed_%0d (%h+%h): got %h expected %h", i, va[i], vb[i], result_o, ve[i]);
      end
    end
  endtask

  // Results appear exactly one edge after sampling; between edges output holds.
  task automatic test_identity_latency();
    @(negedge clk_i);
    add1_i = 32'hABCD_1234;
    add2_i = 32'h0;
    @(posedge clk_i);
    #1;
    add1_i = 32'h0;
    add2_i = 32'h1234_5678;
    n_tests++;
    if (result_o !== 33'h0_ABCD_1234) begin
      n_fail++;
      $display("FAIL identity_a: got %h expected %h", result_o, 33'h0_ABCD_1234);
    end
    #3;
    n_tests++;
    if (result_o !== 33'h0_ABCD_1234) begin
      n_fail++;
      $display("FAIL hold_between_edges: got %h expected %h", result_o, 33'h0_ABCD_1234);
    end
    @(posedge clk_i);
    #1;
    n_tests++;
    if (result_o !== 33'h0_1234_5678) begin
      n_fail++;
      $display("FAIL identity_b_next_edge: got %h expected %h", result_o, 33'h0_1234_5678);
    end
  endtask

  // New random/corner operands every cycle; compare with sum from one edge earlier.
  task automatic test_back_to_back();
    logic [32:0] expq [$];
    logic [32:0] exp_v;
    int          errs;
    errs = 0;
    @(posedge clk_i);
    #1;
    add1_i = pick_operand();
    add2_i = pick_operand();
    expq.push_back(ref_sum(add1_i, add2_i));
    for (int c = 0; c < 1200; c++) begin
      @(posedge clk_i);
      #1;
      exp_v = expq.pop_front();
      n_tests++;
      if (result_o !== exp_v) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL stream_cycle_%0d: got %h expected %h", c, result_o, exp_v);
      end
      add1_i = pick_operand();
      add2_i = pick_operand();
      expq.push_back(ref_sum(add1_i, add2_i));
    end
  endtask

  // Reset asserted between edges clears at once; stream resumes after release.
  task automatic test_async_reset();
    logic [31:0] a;
    logic [31:0] b;
    @(posedge clk_i);
    #1;
    add1_i = 32'hFFFF_FFFF;
    add2_i = 32'hFFFF_FFFF;
    @(posedge clk_i);
    #1;
    n_tests++;
    if (result_o !== 33'h1_FFFF_FFFE) begin
      n_fail++;
      $display("FAIL pre_reset_value: got %h expected %h", result_o, 33'h1_FFFF_FFFE);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    n_tests++;
    if (result_o !== 33'h0) begin
      n_fail++;
      $display("FAIL async_reset_immediate: got %h expected %h", result_o, 33'h0);
    end
    @(posedge clk_i);
    #1;
    n_tests++;
    if (result_o !== 33'h0) begin
      n_fail++;
      $display("FAIL async_reset_held: got %h expected %h", result_o, 33'h0);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a = $urandom;
      b = $urandom;
      add1_i = a;
      add2_i = b;
      @(posedge clk_i);
      #1;
      n_tests++;
      if (result_o !== ref_sum(a, b)) begin
        n_fail++;
        $display("FAIL post_reset_resume_%0d: got %h expected %h", k, result_o, ref_sum(a, b));
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_ni  = 1'b0;
    add1_i  = '0;
    add2_i  = '0;
    test_reset();
    test_directed();
    test_identity_latency();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
